bram_arbiter: RTL

- Two-requester arbiter sharing one dual-port Block RAM: write port A (byte-enabled), read port B (1-cycle synchronous read).
- Write and read channels arbitrated independently, so one write and one read from different requesters can be issued in the same cycle.
- Sits between two internal masters (e.g. CPU-side AHB slave and DMA engine) and the RAM; drives RAM address/data/strobe combinationally and routes read data back with a registered owner tag.

---
 rtl/bram_arbiter_if.sv | 22 ++
 rtl/bram_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/bram_arbiter_if.sv
// bram_arbiter_if: one requester's request/grant/read-return bundle toward the BRAM arbiter.
interface bram_arbiter_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  req;
  logic [3:0]            we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/bram_arbiter.sv
// bram_arbiter: two requesters share a dual-port BRAM (port A byte-enabled write, port B read).
// Optional macro BRAM_ARB_COLLISION_FWD_EN forwards a colliding write into the same-cycle read.
module bram_arbiter #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  RSTn,
  bram_arbiter_if.slave         m0,
  bram_arbiter_if.slave         m1,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);
  localparam int DATA_W = 32;

  logic                  wr_pri, rd_pri;
  logic                  wc0, wc1, rc0, rc1;
  logic                  wr_gnt, wr_sel;
  logic                  rd_req, rd_sel, rd_gnt;
  logic                  collide;
  logic [3:0]            wr_we;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, rd_addr_q;
  logic [DATA_W-1:0]     wr_data, rd_word_p1;
  logic                  vld_p1, rd_owner_p1;
  logic                  rv0, rv1;

  assign wc0 = m0.req && (m0.we != 4'b0000);
  assign wc1 = m1.req && (m1.we != 4'b0000);
  assign rc0 = m0.req && (m0.we == 4'b0000);
  assign rc1 = m1.req && (m1.we == 4'b0000);

  // Stage p0: independent round-robin choice on each channel
  assign wr_gnt  = wc0 || wc1;
  assign wr_sel  = (wc0 && wc1) ? wr_pri : wc1;
  assign rd_req  = rc0 || rc1;
  assign rd_sel  = (rc0 && rc1) ? rd_pri : rc1;

  assign wr_we   = wr_sel ? m1.we    : m0.we;
  assign wr_addr = wr_sel ? m1.addr  : m0.addr;
  assign wr_data = wr_sel ? m1.wdata : m0.wdata;
  assign rd_addr = rd_sel ? m1.addr  : m0.addr;

  assign collide = wr_gnt && rd_req && (wr_addr == rd_addr);

`ifdef BRAM_ARB_COLLISION_FWD_EN
  assign rd_gnt = rd_req;
`else
  // Stall the read one cycle so it observes the RAM after the write lands
  assign rd_gnt = rd_req && !collide;
`endif

  assign m0.gnt = (wr_gnt && !wr_sel) || (rd_gnt && !rd_sel);
  assign m1.gnt = (wr_gnt &&  wr_sel) || (rd_gnt &&  rd_sel);

  assign ram_wea   = wr_gnt ? wr_we   : 4'b0000;
  assign ram_addra = wr_gnt ? wr_addr : '0;
  assign ram_dina  = wr_gnt ? wr_data : '0;
  assign ram_addrb = rd_gnt ? rd_addr : rd_addr_q;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_pri      <= 1'b0;
      rd_pri      <= 1'b0;
      rd_addr_q   <= '0;
      vld_p1      <= 1'b0;
      rd_owner_p1 <= 1'b0;
    end else begin
      if (wr_gnt) wr_pri <= ~wr_pri;
      if (rd_gnt) begin
        rd_pri      <= ~rd_pri;
        rd_addr_q   <= rd_addr;
        rd_owner_p1 <= rd_sel;
      end
      vld_p1 <= rd_gnt;
    end
  end

`ifdef BRAM_ARB_COLLISION_FWD_EN
  localparam int BYTES = DATA_W / 8;

  logic [BYTES-1:0]  fwd_we_p1;
  logic [DATA_W-1:0] fwd_data_p1;

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] base,
                                                   input logic [DATA_W-1:0] fwd,
                                                   input logic [BYTES-1:0]  sel);
    logic [DATA_W-1:0] r;
    r = base;
    for (int k = 0; k < BYTES; k++)
      if (sel[k]) r[8*k +: 8] = fwd[8*k +: 8];
    return r;
  endfunction

  // Stage p1: the RAM returns pre-write data on a collision, so overlay the written bytes
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) fwd_we_p1 <= '0;
    else       fwd_we_p1 <= (collide && rd_gnt) ? wr_we : '0;
  end

  always_ff @(posedge clk) begin
    fwd_data_p1 <= wr_data;
  end

  assign rd_word_p1 = byte_merge(ram_doutb, fwd_data_p1, fwd_we_p1);
`else
  // Stage p1: RAM read data is steered to the owner of last cycle's read
  assign rd_word_p1 = ram_doutb;
`endif

  assign rv0 = vld_p1 && !rd_owner_p1;
  assign rv1 = vld_p1 &&  rd_owner_p1;

  assign m0.rvalid = rv0;
  assign m1.rvalid = rv1;
  assign m0.rdata  = rv0 ? rd_word_p1 : '0;
  assign m1.rdata  = rv1 ? rd_word_p1 : '0;
endmodule
